// File: rtl/carry_skip_adder_16bit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : carry_skip_adder_16bit_pkg
// Description : Shared width constants for the 16-bit carry-skip adder.
// Revision    : 1.0 - initial release
// ============================================================================
package carry_skip_adder_16bit_pkg;

    localparam int CSA_WIDTH   = 16;
    localparam int CSA_BLOCK   = 4;
    localparam int CSA_NBLOCKS = CSA_WIDTH / CSA_BLOCK;

endpackage : carry_skip_adder_16bit_pkg
`default_nettype wire

// File: rtl/carry_skip_adder_16bit_csa_block_4bit.sv
`default_nettype none
// ============================================================================
// Module      : csa_block_4bit
// Description : 4-bit ripple block with block-propagate carry bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_block_4bit
    import carry_skip_adder_16bit_pkg::*;
(
    input  logic [CSA_BLOCK-1:0] x_i,
    input  logic [CSA_BLOCK-1:0] y_i,
    input  logic                 ci_i,
    output logic [CSA_BLOCK-1:0] sum_o,
    output logic                 co_o
);

    logic [CSA_BLOCK-1:0] w_p;
    logic [CSA_BLOCK:0]   w_c;
    logic                 w_blk_p;

    assign w_c[0] = ci_i;

    for (genvar i = 0; i < CSA_BLOCK; i++) begin : g_fa
        assign w_p[i]     = x_i[i] ^ y_i[i];
        assign sum_o[i]   = w_p[i] ^ w_c[i];
        assign w_c[i+1]   = (x_i[i] & y_i[i]) | (w_c[i] & w_p[i]);
    end

    // When every bit propagates, the ripple carry equals ci; bypass the chain.
    assign w_blk_p = &w_p;
    assign co_o    = w_blk_p ? ci_i : w_c[CSA_BLOCK];

endmodule : csa_block_4bit
`default_nettype wire

// File: rtl/carry_skip_adder_16bit.sv
`default_nettype none
// ============================================================================
// Module      : carry_skip_adder_16bit
// Description : Registered 16-bit carry-skip adder, {cout,s} = a + b + cin.
// Revision    : 1.0 - initial release
// ============================================================================
module carry_skip_adder_16bit
    import carry_skip_adder_16bit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CSA_WIDTH-1:0] a_i,
    input  logic [CSA_WIDTH-1:0] b_i,
    input  logic                 cin_i,
    output logic [CSA_WIDTH-1:0] s_o,
    output logic                 cout_o
);

    logic [CSA_NBLOCKS:0]   w_carry;
    logic [CSA_WIDTH-1:0]   w_sum;
    logic [CSA_WIDTH-1:0]   s_d;
    logic                   cout_d;
    logic [CSA_WIDTH-1:0]   s_q;
    logic                   cout_q;

    assign w_carry[0] = cin_i;

    for (genvar k = 0; k < CSA_NBLOCKS; k++) begin : g_block
        csa_block_4bit u_blk (
            .x_i   (a_i[k*CSA_BLOCK +: CSA_BLOCK]),
            .y_i   (b_i[k*CSA_BLOCK +: CSA_BLOCK]),
            .ci_i  (w_carry[k]),
            .sum_o (w_sum[k*CSA_BLOCK +: CSA_BLOCK]),
            .co_o  (w_carry[k+1])
        );
    end

    always_comb begin
        s_d    = w_sum;
        cout_d = w_carry[CSA_NBLOCKS];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
        end
    end

    assign s_o    = s_q;
    assign cout_o = cout_q;

endmodule : carry_skip_adder_16bit
`default_nettype wire

// File: tb/tb_carry_skip_adder_16bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_carry_skip_adder_16bit
// Description : Directed and random checks of the registered carry-skip adder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_carry_skip_adder_16bit;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        cout;

    int n_vec;
    int n_miss;

    carry_skip_adder_16bit dut (
        .clk    (clk),
        .rst    (rst),
        .a_i    (a),
        .b_i    (b),
        .cin_i  (cin),
        .s_o    (s),
        .cout_o (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got {cout,s}=%05h expected %05h", tag, got, exp);
        end
    endtask

    // Drive one vector, clock it in, then sample 1ns after the edge.
    task automatic apply(input logic r, input logic [15:0] va, input logic [15:0] vb,
                         input logic vc, input string tag, input logic [16:0] exp);
        rst = r;
        a   = va;
        b   = vb;
        cin = vc;
        @(posedge clk);
        #1;
        check_eq(tag, {cout, s}, exp);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] rexp;
        n_vec  = 0;
        n_miss = 0;
        rst = 1'b1; a = '0; b = '0; cin = 1'b0;
        @(negedge clk);

        apply(1'b1, 16'hFFFF, 16'h0001, 1'b1, "reset_edge1", 17'h00000);
        apply(1'b1, 16'hFFFF, 16'h0001, 1'b1, "reset_edge2", 17'h00000);

        apply(1'b0, 16'hFFFF, 16'h0000, 1'b1, "full_skip",   17'h10000);
        apply(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, "max_sum",     17'h1FFFF);
        apply(1'b0, 16'h1234, 16'h4321, 1'b0, "pattern_5555",17'h05555);
        apply(1'b0, 16'h0FF0, 16'h0010, 1'b0, "mixed_skip",  17'h01000);
        apply(1'b0, 16'h0000, 16'h0000, 1'b0, "zero",        17'h00000);
        apply(1'b0, 16'h000F, 16'h0000, 1'b1, "blk0_skip",   17'h00010);
        apply(1'b0, 16'h8000, 16'h8000, 1'b0, "msb_carry",   17'h10000);
        apply(1'b0, 16'hF0F0, 16'h0F0F, 1'b0, "alt_prop",    17'h0FFFF);

        // Back-to-back stream with a reset on the middle edge.
        apply(1'b0, 16'h1111, 16'h2222, 1'b1, "b2b_first",   17'h03334);
        apply(1'b1, 16'hAAAA, 16'h5555, 1'b1, "b2b_reset",   17'h00000);
        apply(1'b0, 16'hABCD, 16'h1234, 1'b1, "b2b_third",   17'h0BE02);

        for (int i = 0; i < 10000; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rc   = 1'(i & 1) ^ 1'($urandom_range(0, 1) & (i >> 3));
            rexp = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
            apply(1'b0, ra, rb, rc, "random", rexp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_carry_skip_adder_16bit
`default_nettype wire

// File: doc/carry_skip_adder_16bit.md
# carry_skip_adder_16bit

16-bit carry-skip adder computing {cout, s} = a + b + cin, built from four 4-bit ripple blocks with per-block skip (bypass) logic. The combinational core feeds a single output register stage, so results appear one clock after the operands are sampled. It serves as a datapath arithmetic primitive wherever a registered 16-bit add with carry-in/out is needed.

## Interface
- Parameters: none. Width is fixed at 16 and block size at 4; both are package constants, not overridable.
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- a  input  16  operand A, unsigned
- b  input  16  operand B, unsigned
- cin  input  1  carry-in
- s  output  16  registered sum bits [15:0]
- cout  output  1  registered carry-out (bit 16 of the result)

## Operation
- Result rule: {cout, s} = a + b + cin, computed modulo 2^17, so there is no overflow loss. All operands are unsigned.
- Core datapath: four blocks covering bits [3:0], [7:4], [11:8] and [15:12].
  - Each block ripples through 4 full adders (sum = x^y^c; carry = xy | c(x^y)).
  - Per-bit propagate: p_i = a_i ^ b_i. Block propagate: P = AND of its 4 p_i.
  - Block carry-out = P ? block carry-in : ripple carry-out.
  - Block 0 carry-in = cin. Block k carry-in = block k-1 carry-out. cout = block 3 carry-out.
- The skip mux must be real, not a plain ripple chain. The result must be bit-identical to behavioral a+b+cin for all 2^33 input combinations.
- Register stage: on each rising clk with rst=0, s and cout load the core result of the current a, b and cin.
- Reset: while rst=1 at a rising edge, s=16'h0000 and cout=0. Core inputs are ignored on that edge.
- No enable and no handshake. A new operation is accepted every cycle (throughput 1/cycle).

## Timing
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on s/cout after edge N and hold until edge N+1.
- Outputs after the first edge with rst=1: s=0, cout=0. These remain until the first edge with rst=0.
- Reset mid-stream: the pending result is discarded and the outputs are zero on that edge. Operation resumes on the next non-reset edge.
- Outputs change only on clk edges, never combinationally.
- Critical path: block 0 ripple, then 3 skip muxes, then the block 3 sum ripple.

## Structure
- Shared package: CSA_WIDTH=16, CSA_BLOCK=4, CSA_NBLOCKS=4.
- Sub-module csa_block_4bit:
  - Inputs: 4-bit x, 4-bit y, ci.
  - Outputs: 4-bit sum, co.
  - Contains the 4 ripple full adders, the P computation and the skip mux.
  - The top level instantiates 4 of these in a generate loop, plus the output register.
- A full_adder leaf is optional; it may be inlined in csa_block_4bit.

## Test plan
- Reset: hold rst=1 for 2 edges with a=16'hFFFF, b=16'h0001, cin=1 -> s=16'h0000, cout=0 after each edge.
- Full skip path: a=16'hFFFF, b=16'h0000, cin=1 -> next cycle s=16'h0000, cout=1 (all four blocks propagate).
- Max sum: a=16'hFFFF, b=16'hFFFF, cin=1 -> s=16'hFFFF, cout=1. Also a=16'h1234, b=16'h4321, cin=0 -> s=16'h5555, cout=0.
- Mixed skip/generate: a=16'h0FF0, b=16'h0010, cin=0 -> s=16'h1000, cout=0. Block 1 generates, block 2 propagates (skip).
- Back-to-back plus mid-stream reset:
  - Apply 3 vectors on consecutive cycles. Each result appears exactly 1 cycle later.
  - Assert rst on the 2nd edge -> that result is 0, and the 3rd result is correct.
- Random: at least 10,000 vectors with random a, b and cin in {0,1} (cin must actually toggle) -> compare {cout, s} against a+b+cin delayed one cycle. Zero mismatches.
